// File: rtl/lif_spike_monitor.sv
// lif_spike_monitor
//   Watches the LIF neuron core output stream. Measures inter-spike intervals
//   (ISIs) into a first-word-fall-through FIFO and produces windowed spike-rate
//   counts with the per-window signed peak membrane voltage.
//
//   state  | meaning
//   IDLE   | no spike seen since en rose (or reset); next spike only arms
//   ARMED  | previous spike seen; next spike pushes the current ISI
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   en                  neuron core in work state; gates all monitoring
//   spike_in, v_in      spike flag and (1,6,9) signed membrane voltage
//   win_len             rate window length in en-cycles, 0 disables windowing
//   isi_data/valid/ready  FIFO read port (valid/ready handshake)
//   fifo_level          exact FIFO occupancy
//   overflow            sticky, an ISI was dropped on a full FIFO
//   rate_count, v_peak  results of the last completed window
//   rate_valid          one-cycle pulse when rate_count / v_peak update
module lif_spike_monitor #(
    parameter int FIFO_DEPTH = 8,
    parameter int WIN_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic                          spike_in,
    input  logic [15:0]                   v_in,
    input  logic [WIN_W-1:0]              win_len,
    output logic [15:0]                   isi_data,
    output logic                          isi_valid,
    input  logic                          isi_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic [7:0]                    rate_count,
    output logic [15:0]                   v_peak,
    output logic                          rate_valid
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [15:0] V_MIN = 16'h8000;

    typedef enum logic {IDLE, ARMED} isi_state_t;

    isi_state_t       state_q, state_d;
    logic [15:0]      isi_cnt_q, isi_cnt_d;

    logic [15:0]      mem_q [FIFO_DEPTH];
    logic [15:0]      mem_d [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic [15:0]      isi_data_q, isi_data_d;
    logic             isi_valid_q, isi_valid_d;
    logic             overflow_q, overflow_d;

    logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
    logic [7:0]       spike_acc_q, spike_acc_d;
    logic [15:0]      win_max_q, win_max_d;
    logic [7:0]       rate_count_q, rate_count_d;
    logic [15:0]      v_peak_q, v_peak_d;
    logic             rate_valid_q, rate_valid_d;

    logic             push_req, push, pop, full;
    logic [15:0]      head_next;
    logic             win_active, win_close;
    logic [8:0]       acc_sum;
    logic [7:0]       acc_sat;
    logic [15:0]      v_max;

    // ISI measurement
    always_comb begin
        state_d   = state_q;
        isi_cnt_d = isi_cnt_q;
        if (en) begin
            if (spike_in) begin
                isi_cnt_d = 16'd1;
                state_d   = ARMED;
            end else if (isi_cnt_q != 16'hFFFF) begin
                isi_cnt_d = isi_cnt_q + 16'd1;
            end
        end else begin
            state_d = IDLE;
        end
    end

    // FIFO
    always_comb begin
        pop        = isi_valid_q & isi_ready;
        full       = (level_q == LW'(FIFO_DEPTH));
        push_req   = en & spike_in & (state_q == ARMED);
        // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
        push       = push_req & (~full | pop);
        overflow_d = overflow_q | (push_req & full & ~pop);

        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = isi_cnt_q;
        end
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

        unique case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

        // The registered head must bypass the memory when the entry being pushed
        // becomes the new head (push into empty, or push+pop of the last entry).
        head_next   = (push && (rd_ptr_d == wr_ptr_q)) ? isi_cnt_q : mem_q[rd_ptr_d];
        isi_valid_d = (level_d != '0);
        isi_data_d  = isi_valid_d ? head_next : isi_data_q;
    end

    // Rate window
    always_comb begin
        win_active = en & (win_len != '0);
        win_close  = (win_cnt_q >= win_len - WIN_W'(1));
        acc_sum    = {1'b0, spike_acc_q} + {8'd0, spike_in};
        acc_sat    = acc_sum[8] ? 8'hFF : acc_sum[7:0];
        v_max      = ($signed(v_in) > $signed(win_max_q)) ? v_in : win_max_q;

        win_cnt_d    = win_cnt_q;
        spike_acc_d  = spike_acc_q;
        win_max_d    = win_max_q;
        rate_count_d = rate_count_q;
        v_peak_d     = v_peak_q;
        rate_valid_d = 1'b0;

        if (win_active) begin
            if (win_close) begin
                rate_count_d = acc_sat;
                v_peak_d     = v_max;
                rate_valid_d = 1'b1;
                win_cnt_d    = '0;
                spike_acc_d  = 8'd0;
                win_max_d    = V_MIN;
            end else begin
                win_cnt_d    = win_cnt_q + WIN_W'(1);
                spike_acc_d  = acc_sat;
                win_max_d    = v_max;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            isi_cnt_q    <= 16'd0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            isi_data_q   <= 16'd0;
            isi_valid_q  <= 1'b0;
            overflow_q   <= 1'b0;
            win_cnt_q    <= '0;
            spike_acc_q  <= 8'd0;
            win_max_q    <= V_MIN;
            rate_count_q <= 8'd0;
            v_peak_q     <= V_MIN;
            rate_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            isi_cnt_q    <= isi_cnt_d;
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            isi_data_q   <= isi_data_d;
            isi_valid_q  <= isi_valid_d;
            overflow_q   <= overflow_d;
            win_cnt_q    <= win_cnt_d;
            spike_acc_q  <= spike_acc_d;
            win_max_q    <= win_max_d;
            rate_count_q <= rate_count_d;
            v_peak_q     <= v_peak_d;
            rate_valid_q <= rate_valid_d;
        end
    end

    assign isi_data   = isi_data_q;
    assign isi_valid  = isi_valid_q;
    assign fifo_level = level_q;
    assign overflow   = overflow_q;
    assign rate_count = rate_count_q;
    assign v_peak     = v_peak_q;
    assign rate_valid = rate_valid_q;

endmodule

// File: tb/tb_lif_spike_monitor.sv
// Scoreboard bench for lif_spike_monitor: stimulus pushes hand-computed
// expected ISIs and window results into queues; a negedge monitor pops and
// compares whenever the DUT presents an ISI handshake or a rate_valid pulse.
module tb_lif_spike_monitor;
    logic        clk = 1'b0;
    logic        rst, en, spike_in, isi_ready;
    logic [15:0] v_in, win_len;
    logic [15:0] isi_data, v_peak;
    logic        isi_valid, overflow, rate_valid;
    logic [3:0]  fifo_level;
    logic [7:0]  rate_count;

    lif_spike_monitor #(.FIFO_DEPTH(8), .WIN_W(16)) dut (
        .clk(clk), .rst(rst), .en(en), .spike_in(spike_in), .v_in(v_in),
        .win_len(win_len), .isi_data(isi_data), .isi_valid(isi_valid),
        .isi_ready(isi_ready), .fifo_level(fifo_level), .overflow(overflow),
        .rate_count(rate_count), .v_peak(v_peak), .rate_valid(rate_valid)
    );

    always #5 clk = ~clk;

    int          n_pass = 0;
    int          n_chk  = 0;
    logic [15:0] isi_q[$];
    logic [23:0] rate_q[$];
    logic [15:0] mon_e;
    logic [23:0] mon_r;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic step(input logic s, input logic [15:0] v);
        spike_in = s;
        v_in     = v;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b0, 16'd0);
        rst = 1'b0;
    endtask

    // Monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (isi_valid && isi_ready) begin
                if (isi_q.size() == 0) chk("isi_unexpected", 32'd1, 32'd0);
                else begin
                    mon_e = isi_q.pop_front();
                    chk("isi_data", {16'd0, isi_data}, {16'd0, mon_e});
                end
            end
            if (rate_valid) begin
                if (rate_q.size() == 0) chk("rate_unexpected", 32'd1, 32'd0);
                else begin
                    mon_r = rate_q.pop_front();
                    chk("rate_count", {24'd0, rate_count}, {24'd0, mon_r[23:16]});
                    chk("v_peak", {16'd0, v_peak}, {16'd0, mon_r[15:0]});
                end
            end
        end
    end

    initial begin
        rst = 1'b1; en = 1'b0; spike_in = 1'b0; v_in = 16'd0;
        win_len = 16'd0; isi_ready = 1'b0;
        @(posedge clk); #1;
        chk("rst_isi_valid", {31'd0, isi_valid}, 32'd0);
        chk("rst_isi_data", {16'd0, isi_data}, 32'd0);
        chk("rst_level", {28'd0, fifo_level}, 32'd0);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);
        chk("rst_rate_count", {24'd0, rate_count}, 32'd0);
        chk("rst_v_peak", {16'd0, v_peak}, 32'h8000);
        chk("rst_rate_valid", {31'd0, rate_valid}, 32'd0);
        rst = 1'b0;

        // Basic ISI: spikes at 10, 15, 16, 40
        en = 1'b1; isi_ready = 1'b1;
        for (int c = 0; c < 46; c++) begin
            if (c == 15) isi_q.push_back(16'd5);
            if (c == 16) isi_q.push_back(16'd1);
            if (c == 40) isi_q.push_back(16'd24);
            step(c == 10 || c == 15 || c == 16 || c == 40, 16'd0);
        end
        chk("t1_drained", 32'(isi_q.size()), 32'd0);
        chk("t1_overflow", {31'd0, overflow}, 32'd0);
        chk("t1_empty", {31'd0, isi_valid}, 32'd0);

        // Overflow: 10 spikes 3 apart, no reads
        do_reset();
        isi_ready = 1'b0;
        for (int c = 0; c < 30; c++) begin
            if ((c % 3) == 0 && c > 0 && c <= 24) isi_q.push_back(16'd3);
            step((c % 3) == 0, 16'd0);
            if (c == 24) begin
                chk("ovf_level8", {28'd0, fifo_level}, 32'd8);
                chk("ovf_not_yet", {31'd0, overflow}, 32'd0);
            end
        end
        chk("ovf_level_full", {28'd0, fifo_level}, 32'd8);
        chk("ovf_set", {31'd0, overflow}, 32'd1);
        // Full FIFO: push and pop in the same cycle
        isi_ready = 1'b1;
        isi_q.push_back(16'd3);
        step(1'b1, 16'd0);
        isi_ready = 1'b0;
        chk("full_pp_level", {28'd0, fifo_level}, 32'd8);
        chk("full_pp_overflow", {31'd0, overflow}, 32'd1);
        isi_ready = 1'b1;
        for (int c = 0; c < 10; c++) step(1'b0, 16'd0);
        chk("ovf_drained", 32'(isi_q.size()), 32'd0);
        chk("ovf_level0", {28'd0, fifo_level}, 32'd0);
        chk("ovf_sticky", {31'd0, overflow}, 32'd1);

        // Window of 20 with ramp, spikes at 0, 5, 19
        do_reset();
        win_len = 16'd20;
        for (int i = 0; i < 20; i++) begin
            if (i == 5)  isi_q.push_back(16'd5);
            if (i == 19) begin
                isi_q.push_back(16'd14);
                rate_q.push_back({8'd3, 16'd200});
            end
            step(i == 0 || i == 5 || i == 19, (i == 19) ? 16'd200 : 16'(-300 + i * 25));
            if (i == 18) chk("win_no_early", {31'd0, rate_valid}, 32'd0);
        end
        chk("win_pulse", {31'd0, rate_valid}, 32'd1);
        step(1'b0, 16'd0);
        chk("win_pulse_1cyc", {31'd0, rate_valid}, 32'd0);
        step(1'b0, 16'd0);
        chk("win_q_done", 32'(rate_q.size()), 32'd0);

        // Saturation: spikes every cycle over a 300-cycle window
        do_reset();
        win_len = 16'd300;
        for (int i = 0; i < 300; i++) begin
            if (i > 0) isi_q.push_back(16'd1);
            if (i == 299) rate_q.push_back({8'd255, 16'd0});
            step(1'b1, 16'd0);
        end
        for (int i = 0; i < 3; i++) step(1'b0, 16'd0);
        chk("sat_rate_done", 32'(rate_q.size()), 32'd0);
        chk("sat_isi_done", 32'(isi_q.size()), 32'd0);

        // en dropped for 50 cycles between spikes
        do_reset();
        win_len = 16'd10;
        for (int i = 0; i < 6; i++) step(i == 2, (i == 1) ? 16'd300 : 16'd100);
        en = 1'b0;
        for (int i = 0; i < 50; i++) step(1'b1, 16'h7FFF);
        chk("en_off_no_isi", {31'd0, isi_valid}, 32'd0);
        en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i == 3) rate_q.push_back({8'd2, 16'd300});
            if (i == 4) isi_q.push_back(16'd4);
            step(i == 0 || i == 4, 16'hFFCE);
        end
        step(1'b0, 16'd0);
        chk("en_rate_done", 32'(rate_q.size()), 32'd0);
        chk("en_isi_done", 32'(isi_q.size()), 32'd0);

        // Reset mid-operation, then live shrink of win_len
        do_reset();
        win_len = 16'd20; isi_ready = 1'b0;
        for (int c = 0; c < 10; c++) step((c % 2) == 0, 16'd1000);
        chk("mid_level4", {28'd0, fifo_level}, 32'd4);
        rst = 1'b1;
        step(1'b0, 16'd0);
        rst = 1'b0;
        chk("mid_rst_valid", {31'd0, isi_valid}, 32'd0);
        chk("mid_rst_level", {28'd0, fifo_level}, 32'd0);
        chk("mid_rst_v_peak", {16'd0, v_peak}, 32'h8000);
        chk("mid_rst_overflow", {31'd0, overflow}, 32'd0);
        isi_ready = 1'b1;
        step(1'b0, 16'd5);
        step(1'b1, 16'd5);
        for (int c = 0; c < 3; c++) step(1'b0, 16'd5);
        win_len = 16'd3;
        rate_q.push_back({8'd1, 16'd7});
        step(1'b0, 16'd7);
        win_len = 16'd0;
        step(1'b0, 16'd0);
        step(1'b0, 16'd0);
        chk("shrink_rate_done", 32'(rate_q.size()), 32'd0);
        chk("final_isi_done", 32'(isi_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/lif_spike_monitor.md
Name: lif_spike_monitor

Overview:
- Consumes the LIF neuron core's output stream: the spike bit and the 16-bit signed membrane voltage vout, in (1,6,9) fixed point.
- Measures inter-spike intervals (ISIs) and buffers them in a small FIFO with a valid/ready read port.
- Produces windowed spike-rate counts and the per-window peak membrane voltage.
- Sits directly downstream of the neuron core; its inputs are active only while the core is in its work state.

Parameters:
- FIFO_DEPTH, 8, number of ISI entries buffered; power of two, 2..16.
- WIN_W, 16, width of the rate-window length and window counter.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  neuron core in work state; all monitoring is gated by this.
- spike_in  input  1  spike flag from the neuron core, valid on the same cycle as v_in.
- v_in  input  16  membrane voltage, signed two's complement (1,6,9).
- win_len  input  WIN_W  rate window length in en-cycles; 0 disables windowing.
- isi_data  output  16  ISI at the FIFO head, in clock cycles.
- isi_valid  output  1  FIFO non-empty.
- isi_ready  input  1  consumer accepts isi_data when isi_valid and isi_ready are both high.
- fifo_level  output  $clog2(FIFO_DEPTH)+1  current occupancy.
- overflow  output  1  sticky; an ISI was dropped because the FIFO was full.
- rate_count  output  8  spikes in the last completed window.
- v_peak  output  16  maximum signed v_in seen in the last completed window.
- rate_valid  output  1  one-cycle pulse when rate_count and v_peak update.

Behaviour:

Reset (rst high at a clock edge; takes priority over all other activity):
- isi_valid=0, isi_data=0, fifo_level=0, overflow=0, rate_count=0, v_peak=0x8000, rate_valid=0.
- Internal state cleared: armed=0, isi_cnt=0, win_cnt=0, spike_acc=0, FIFO pointers=0, window max=0x8000.
- Reset mid-operation discards FIFO contents and any partial window.

ISI measurement (only while en=1):
- State machine: IDLE (armed=0) -> ARMED on the first spike_in.
- In IDLE, a spike only arms the counter; nothing is pushed.
- On any spike, isi_cnt loads 1. On non-spike cycles, isi_cnt increments, saturating at 0xFFFF.
- In ARMED, a spike pushes the current isi_cnt, then reloads 1. Spikes at cycles t0 and t1 therefore push t1-t0; back-to-back spikes push 1.
- en=0: isi_cnt holds, armed clears to IDLE, no pushes.

FIFO:
- First-word-fall-through: isi_data shows the head entry while isi_valid=1. isi_data holds its last value when empty.
- Push and pop both happen in the same cycle they are requested. A pushed value appears at the output on the next cycle if the FIFO was empty.
- Full with push and no pop: the value is dropped and overflow sets; overflow clears only on rst.
- Full with simultaneous push and pop: both occur, level unchanged, no overflow.
- Empty with simultaneous push and pop request: the pop is ignored because isi_valid=0; the push occurs.
- Pointers wrap modulo FIFO_DEPTH. fifo_level is exact.

Rate window (only while en=1 and win_len!=0):
- win_cnt increments every en cycle.
- spike_acc counts spikes, saturating at 255.
- The window max register holds the signed maximum of v_in; comparison is signed.
- Close condition: win_cnt >= win_len-1. This comparison is live, so shrinking win_len mid-window closes it on the next cycle.
- On the close cycle:
  - rate_count <= sat255(spike_acc + spike_in).
  - v_peak <= signed max(window max, v_in).
  - rate_valid=1 for one cycle.
  - win_cnt, spike_acc and window max reinitialise (0, 0, 0x8000).
- en=0 or win_len=0: window state holds and rate_valid stays 0.

Latency:
- Spike at cycle t: the FIFO entry is visible (isi_valid=1) at t+1.
- Window close on cycle t: rate_valid is high during t+1.

Test Plan:
- rst, en=1, spikes at cycles 10, 15, 16, 40, isi_ready=1 -> isi_data sequence 5, 1, 24; the first spike produces no entry; overflow=0.
- FIFO_DEPTH=8, isi_ready=0, 10 spikes spaced 3 cycles apart -> 9 ISIs generated; fifo_level=8; overflow=1 after the 9th ISI; after draining, isi_data is 3 eight times.
- FIFO full, push and pop in the same cycle -> fifo_level stays 8; overflow stays at its prior value.
- win_len=20, spikes at window cycles 0, 5, 19, v_in ramp -300..+200 -> a rate_valid pulse after the 20th en cycle with rate_count=3 and v_peak=200. Spikes every cycle for 300 cycles with win_len=300 -> rate_count=255.
- en dropped for 50 cycles between two spikes -> no ISI pushed for the spike after re-enable; window counters frozen during en=0.
- rst asserted with 4 entries queued and a half-complete window -> next cycle isi_valid=0, fifo_level=0, v_peak=0x8000, overflow=0.
